rca_pipe_addsub: RTL

//   Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes.

---
 rtl/rca_pipe_addsub_if.sv | 27 ++
 rtl/rca_pipe_addsub.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rca_pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder/subtractor.
// The slave view belongs to the adder, the master view to the producer/consumer side.
interface rca_pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: the carry chain is cut into STAGES
// registered segments of WIDTH/STAGES bits, with an elastic valid/ready pipeline.
module rca_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  rca_pipe_addsub_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  function automatic logic [SEG:0] ripple(input logic [SEG-1:0] a,
                                          input logic [SEG-1:0] b,
                                          input logic           c);
    logic [SEG-1:0] s;
    logic           cy;
    s  = '0;
    cy = c;
    for (int i = 0; i < SEG; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    return {cy, s};
  endfunction

  // Subtraction is A + ~B + ~borrow, so only B and the carry-in are remapped.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             accept;

  assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c_eff = bus.in_sub ? ~bus.in_cin : bus.in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           c_i;
    logic           v_i;
    logic           ld;
    logic           drain;
    logic [SEG:0]   r;
    logic           vld_p;
    logic           c_p;
    logic [HI-1:0]  sum_p;

    assign r  = ripple(a_seg, b_seg, c_i);
    assign ld = !vld_p || drain;

    if (k == STAGES - 1) begin : g_dr
      assign drain = bus.out_ready;
    end else begin : g_dr
      assign drain = g_st[k+1].ld;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        c_p   <= 1'b0;
      end else if (ld) begin
        vld_p <= v_i;
        if (v_i) c_p <= r[SEG];
      end
    end

    // Stage boundary: segment k consumes the low slice of what stage k-1 left over.
    if (k == 0) begin : g_src
      assign a_seg = bus.in_a[SEG-1:0];
      assign b_seg = b_eff[SEG-1:0];
      assign c_i   = c_eff;
      assign v_i   = accept;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          sum_p <= '0;
        else if (ld && v_i)  sum_p <= r[SEG-1:0];
      end
    end else begin : g_src
      assign a_seg = g_st[k-1].g_rem.a_p[SEG-1:0];
      assign b_seg = g_st[k-1].g_rem.b_p[SEG-1:0];
      assign c_i   = g_st[k-1].c_p;
      assign v_i   = g_st[k-1].vld_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          sum_p <= '0;
        else if (ld && v_i)  sum_p <= {r[SEG-1:0], g_st[k-1].sum_p};
      end
    end

    if (k < STAGES - 1) begin : g_rem
      localparam int RW = WIDTH - HI;
      logic [RW-1:0] a_src;
      logic [RW-1:0] b_src;
      logic [RW-1:0] a_p;
      logic [RW-1:0] b_p;

      if (k == 0) begin : g_in
        assign a_src = bus.in_a[WIDTH-1:HI];
        assign b_src = b_eff[WIDTH-1:HI];
      end else begin : g_in
        assign a_src = g_st[k-1].g_rem.a_p[WIDTH-LO-1:SEG];
        assign b_src = g_st[k-1].g_rem.b_p[WIDTH-LO-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_p <= '0;
          b_p <= '0;
        end else if (ld && v_i) begin
          a_p <= a_src;
          b_p <= b_src;
        end
      end
    end else begin : g_ovf
      // Overflow = carry into the MSB xor carry out of it; the former is rebuilt from the MSB sum bit.
      logic msb_c;
      logic ovf_p;
      assign msb_c = a_seg[SEG-1] ^ b_seg[SEG-1] ^ r[SEG-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ovf_p <= 1'b0;
        else if (ld && v_i)  ovf_p <= msb_c ^ r[SEG];
      end
    end
  end

  assign bus.in_ready  = rst_n && g_st[0].ld;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = g_st[STAGES-1].vld_p;
  assign bus.out_sum   = g_st[STAGES-1].sum_p;
  assign bus.out_cout  = g_st[STAGES-1].c_p;
  assign bus.out_ovf   = g_st[STAGES-1].g_ovf.ovf_p;
endmodule
